// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable
// UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP,
    CLEANUP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_bits(
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    return data_bits + ((parity != PAR_NONE) ? 1 : 0)
      + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 2-flop synchroniser and 3-sample
// majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int CW = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          rx_serial,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] mid,
  output logic          rx_sync,
  output logic          rx_high,
  output logic          vote,
  output logic          vote_valid
);

  logic       meta;
  logic       s0;
  logic       s1;
  logic [1:0] fill;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      fill    <= 2'b00;
      s0      <= 1'b1;
      s1      <= 1'b1;
    end else begin
      meta    <= rx_serial;
      rx_sync <= meta;
      fill    <= {fill[0], 1'b1};
      if (en && cnt == mid - CW'(1)) s0 <= rx_sync;
      if (en && cnt == mid) s1 <= rx_sync;
    end
  end

  // the synchroniser's reset value is not a real line sample
  assign rx_high    = rx_sync & fill[1];
  assign vote_valid = en && (cnt == mid + CW'(1));
  assign vote = (s0 & s1) | (s0 & rx_sync)
              | (s1 & rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver delivering one
// voted word per frame with parity/framing/break flags.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW =
    $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS) + 1);
  localparam logic [CW-1:0] MID =
    CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IW-1:0]  idx, idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic           armed;
  logic           par_acc;
  logic           any_one;
  logic           ferr;
  logic           ferr_n;
  logic           perr;
  logic           load;
  logic           win_end;
  logic           en;
  logic           rx_sync;
  logic           rx_high;
  logic           vote;
  logic           vote_valid;

  assign en = (state != IDLE) && (state != CLEANUP);

  uart_rx_sampler #(.CW(CW)) u_sampler (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .rx_serial  (i_Rx_Serial),
    .en         (en),
    .cnt        (cnt),
    .mid        (MID),
    .rx_sync    (rx_sync),
    .rx_high    (rx_high),
    .vote       (vote),
    .vote_valid (vote_valid)
  );

  assign win_end = (cnt == LAST_CNT);
  assign load    = (state == STOP) && vote_valid
                && (idx == LAST_STOP);
  assign ferr_n  = ferr | ~vote;
  assign o_Busy  = (state != IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = win_end ? '0 : cnt + CW'(1);
    idx_n   = idx;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (armed && !rx_sync) state_n = START;
      end
      START: begin
        if (vote_valid && vote) state_n = IDLE;
        else if (win_end) state_n = DATA;
      end
      DATA: begin
        if (win_end) begin
          if (idx == LAST_DATA) begin
            idx_n   = '0;
            state_n = (PARITY != PAR_NONE) ? PARITY_BIT
                                           : STOP;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PARITY_BIT: begin
        if (win_end) state_n = STOP;
      end
      STOP: begin
        // leave on the last stop vote for back-to-back margin
        if (load) state_n = CLEANUP;
        else if (win_end) idx_n = idx + IW'(1);
      end
      CLEANUP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    perr = 1'b0;
    if (PARITY == PAR_ODD) perr = ~par_acc;
    else if (PARITY == PAR_EVEN) perr = par_acc;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      armed        <= 1'b0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      any_one      <= 1'b0;
      ferr         <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      if (state == IDLE) begin
        par_acc <= 1'b0;
        any_one <= 1'b0;
        ferr    <= 1'b0;
        if (rx_high) armed <= 1'b1;
      end
      if (vote_valid &&
          (state == DATA || state == PARITY_BIT)) begin
        par_acc <= par_acc ^ vote;
        any_one <= any_one | vote;
        if (state == DATA)
          shreg <= {vote, shreg[DATA_BITS-1:1]};
      end
      if (vote_valid && state == STOP) ferr <= ferr_n;
      if (load) begin
        o_Rx_DV      <= 1'b1;
        o_Rx_Byte    <= shreg;
        o_Parity_Err <= perr;
        o_Frame_Err  <= ferr_n;
        o_Break      <= ferr_n & ~any_one;
        // a bad frame must see the line go high again
        if (ferr_n) armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of the configurable UART
// receiver (8N1 and 8E1 instances, 16 clocks per bit).
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic       dv_a, pe_a, fe_a, bk_a, busy_a;
  logic       dv_b, pe_b, fe_b, bk_b, busy_b;
  logic [7:0] byte_a, byte_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int na = 0, nb = 0, dbl = 0, a_cyc = 0;
  logic [7:0] a_byte = '0, b_byte = '0;
  logic a_pe = 0, a_fe = 0, a_bk = 0;
  logic b_pe = 0, b_fe = 0, b_bk = 0;
  logic pa = 0, pb = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1)
  ) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a),
    .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a),
    .o_Break(bk_a), .o_Busy(busy_a)
  );

  uart_rx_cfg #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1)
  ) dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b),
    .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b),
    .o_Break(bk_b), .o_Busy(busy_b)
  );

  always @(negedge clk) begin
    if (dv_a) begin
      na++;
      a_cyc = cyc;
      a_byte = byte_a;
      a_pe = pe_a; a_fe = fe_a; a_bk = bk_a;
    end
    if (dv_b) begin
      nb++;
      b_byte = byte_b;
      b_pe = pe_b; b_fe = fe_b; b_bk = bk_b;
    end
    if ((dv_a && pa) || (dv_b && pb)) dbl++;
    pa = dv_a;
    pb = dv_b;
  end

  function automatic logic [15:0] frame8(input logic [7:0] b);
    return {6'b0, 1'b1, b, 1'b0};
  endfunction

  function automatic logic [15:0] framep(
    input logic [7:0] b, input logic p);
    return {5'b0, 1'b1, p, b, 1'b0};
  endfunction

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic send_bits(input bit sel,
    input logic [15:0] bits, input int n, input int spike);
    for (int i = 0; i < n; i++) begin
      set_line(sel, bits[i]);
      if (i == spike) begin
        repeat (8) @(negedge clk);
        set_line(sel, ~bits[i]);
        @(negedge clk);
        set_line(sel, bits[i]);
        repeat (7) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dv_a, pe_a, fe_a, bk_a, busy_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags_a got=%b want=00000",
        {dv_a, pe_a, fe_a, bk_a, busy_a});
    end
    checks++;
    if (byte_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte_a got=%h want=00", byte_a);
    end
    checks++;
    if ({dv_b, pe_b, fe_b, bk_b, busy_b, byte_b} !== 13'b0)
    begin
      errors++;
      $display("FAIL reset_b got=%b want=0",
        {dv_b, pe_b, fe_b, bk_b, busy_b, byte_b});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_frames();
    int c0, n0;
    c0 = cyc;
    n0 = na;
    send_bits(0, frame8(8'hA5), 10, -1);
    #1;
    checks++;
    if (na !== n0 + 1 || a_cyc !== c0 + 156) begin
      errors++;
      $display("FAIL a5_timing got n=%0d cyc=%0d want n=%0d cyc=%0d",
        na - n0, a_cyc - c0, 1, 156);
    end
    checks++;
    if (a_byte !== 8'hA5 || {a_pe, a_fe, a_bk} !== 3'b0) begin
      errors++;
      $display("FAIL a5_data got=%h/%b want=a5/000",
        a_byte, {a_pe, a_fe, a_bk});
    end
    send_bits(0, frame8(8'h3C), 10, -1);
    #1;
    checks++;
    if (na !== n0 + 2 || a_cyc !== c0 + 316) begin
      errors++;
      $display("FAIL b2b_timing got n=%0d cyc=%0d want n=%0d cyc=%0d",
        na - n0, a_cyc - c0, 2, 316);
    end
    checks++;
    if (a_byte !== 8'h3C || {a_pe, a_fe, a_bk} !== 3'b0) begin
      errors++;
      $display("FAIL b2b_data got=%h/%b want=3c/000",
        a_byte, {a_pe, a_fe, a_bk});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    int n0;
    n0 = na;
    set_line(0, 1'b0);
    repeat (5) @(negedge clk);
    set_line(0, 1'b1);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy got=%b want=1", busy_a);
    end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0 || na !== n0) begin
      errors++;
      $display("FAIL glitch_idle got busy=%b n=%0d want 0/0",
        busy_a, na - n0);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_parity();
    int n0;
    n0 = nb;
    send_bits(1, framep(8'h37, 1'b0), 11, -1);
    #1;
    checks++;
    if (nb !== n0 + 1 || b_byte !== 8'h37 || b_pe !== 1'b1
        || b_fe !== 1'b0) begin
      errors++;
      $display("FAIL par_bad got n=%0d %h pe=%b fe=%b want 1 37 1 0",
        nb - n0, b_byte, b_pe, b_fe);
    end
    send_bits(1, framep(8'h37, 1'b1), 11, -1);
    #1;
    checks++;
    if (nb !== n0 + 2 || b_byte !== 8'h37 || b_pe !== 1'b0
        || b_fe !== 1'b0) begin
      errors++;
      $display("FAIL par_ok got n=%0d %h pe=%b fe=%b want 2 37 0 0",
        nb - n0, b_byte, b_pe, b_fe);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_spike();
    int n0;
    n0 = na;
    a_byte = 8'hFF;
    send_bits(0, frame8(8'h00), 10, 4);
    #1;
    checks++;
    if (na !== n0 + 1 || a_byte !== 8'h00
        || {a_pe, a_fe, a_bk} !== 3'b0) begin
      errors++;
      $display("FAIL spike got n=%0d %h/%b want 1 00/000",
        na - n0, a_byte, {a_pe, a_fe, a_bk});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_break();
    int n0;
    n0 = na;
    set_line(0, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    #1;
    checks++;
    if (na !== n0 + 1 || a_bk !== 1'b1 || a_fe !== 1'b1
        || a_byte !== 8'h00) begin
      errors++;
      $display("FAIL break got n=%0d bk=%b fe=%b %h want 1 1 1 00",
        na - n0, a_bk, a_fe, a_byte);
    end
    set_line(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    send_bits(0, frame8(8'h55), 10, -1);
    #1;
    checks++;
    if (na !== n0 + 2 || a_byte !== 8'h55
        || {a_pe, a_fe, a_bk} !== 3'b0) begin
      errors++;
      $display("FAIL after_break got n=%0d %h/%b want 2 55/000",
        na - n0, a_byte, {a_pe, a_fe, a_bk});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n0, hits;
    n0 = na;
    hits = 0;
    set_line(0, 1'b0);
    repeat (5 * CPB + 8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({dv_a, pe_a, fe_a, bk_a, busy_a, byte_a} !== 13'b0)
    begin
      errors++;
      $display("FAIL abort_outputs got=%b want=0",
        {dv_a, pe_a, fe_a, bk_a, busy_a, byte_a});
    end
    for (int i = 0; i < 4 * CPB; i++) begin
      @(negedge clk);
      if (busy_a) hits++;
    end
    #1;
    checks++;
    if (hits !== 0 || na !== n0) begin
      errors++;
      $display("FAIL abort_unarmed got busy=%0d n=%0d want 0 0",
        hits, na - n0);
    end
    set_line(0, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    send_bits(0, frame8(8'hC3), 10, -1);
    #1;
    checks++;
    if (na !== n0 + 1 || a_byte !== 8'hC3
        || {a_pe, a_fe, a_bk} !== 3'b0) begin
      errors++;
      $display("FAIL after_abort got n=%0d %h/%b want 1 c3/000",
        na - n0, a_byte, {a_pe, a_fe, a_bk});
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_no_double();
    checks++;
    if (dbl !== 0) begin
      errors++;
      $display("FAIL dv_double got=%0d want=0", dbl);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frames();
    test_glitch();
    test_parity();
    test_spike();
    test_break();
    test_reset_abort();
    test_no_double();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver replacing the fixed 8N1 receiver on the serial input path. It supports configurable data width, parity mode and stop-bit count. Each bit is decided by a 3-sample majority vote around mid-bit, and parity, framing and break conditions are reported alongside each received word. It sits between the board RX pin and the command/byte consumers, and delivers one word per frame on a single-cycle valid strobe.

## Interface
- CLKS_PER_BIT, 868: i_Clock cycles per bit; must be ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.

- i_Clock  in  1  sole clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line, idle high.
- o_Rx_DV  out  1  one-cycle strobe; word and flags valid.
- o_Rx_Byte  out  DATA_BITS  received word; held until the next strobe.
- o_Parity_Err  out  1  parity mismatch; always 0 when PARITY=0.
- o_Frame_Err  out  1  a stop bit voted 0.
- o_Break  out  1  data, parity and stop bits all 0.
- o_Busy  out  1  high in every state other than IDLE.

## Operation
- Input passes through a 2-flop synchroniser, reset to 1.
- Constants:
  - mid = (CLKS_PER_BIT-1)/2.
  - The counter is $clog2(CLKS_PER_BIT) bits wide and runs 0..CLKS_PER_BIT-1 in every bit window.
  - Samples are taken at counts mid-1, mid and mid+1.
  - The bit is decided on the edge that processes count mid+1, by majority of 3.
- State IDLE:
  - Counter and bit index are cleared.
  - An internal `armed` flag sets when the synchronised line is 1.
  - If `armed` is set and the line is 0, go to START.
- State START:
  - Vote 1 (glitch): go to IDLE with no strobe.
  - Vote 0: at the window end, go to DATA.
- State DATA:
  - The vote shifts into the internal shift register LSB first.
  - After DATA_BITS windows, go to PARITY, or to STOP if PARITY=0.
- State PARITY:
  - Voted bit is checked against the data: odd means the total count of ones including the parity bit is odd; even means it is even.
- State STOP:
  - The vote in each stop window is checked.
  - On the vote edge of the last stop bit, do not wait for the window end; go to CLEANUP. This early exit gives half-bit margin for back-to-back frames.
- State CLEANUP:
  - Lasts one cycle.
  - o_Rx_DV=1.
  - The shift register loads into o_Rx_Byte; flags load at the same edge.
  - Next state is IDLE.
- Flags:
  - Any stop vote of 0 sets Frame_Err.
  - Break = Frame_Err and all data/parity votes 0.
  - Break or Frame_Err clears `armed`, so the line must return high before a new start bit is accepted.
- Errored frames still strobe o_Rx_DV and deliver the word.
- Reset:
  - State goes to IDLE; counter and index go to 0.
  - All outputs go to 0, including o_Rx_Byte.
  - `armed` goes to 0.
  - A frame in progress is aborted with no strobe.

## Timing
- Let edge k be the first edge sampling i_Rx_Serial=0. START is entered at edge k+2.
- Bit b (start = 0), count c is processed at edge k+3+b·CLKS_PER_BIT+c.
- o_Rx_DV is high in the cycle after edge k+3+N·CLKS_PER_BIT+mid+1, with N = DATA_BITS + (PARITY≠0) + STOP_BITS.
- o_Rx_DV is never high on consecutive cycles.
- The earliest next start edge is the cycle after the strobe. IDLE is entered in that same cycle.
- Reset asserted on the same edge as a CLEANUP strobe wins: no strobe is issued.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, CLEANUP);
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a function computing N from the parameters.
- Sub-module uart_rx_sampler holds the synchroniser and the 3-sample majority vote. It takes the count and mid, and outputs the voted bit and a vote-valid pulse.
- The top level holds the FSM, shift register, parity accumulator and output registers.

## Test plan
- CLKS_PER_BIT=16, 8N1, send 0xA5 with k at frame start:
  - o_Rx_DV rises after edge k+155, o_Rx_Byte=0xA5, all flags 0.
  - A second frame with zero idle gap, 0x3C: a second strobe 160 cycles later, byte 0x3C.
- Line low for 5 cycles, then high: no strobe, o_Busy returns to 0 within 10 cycles.
- PARITY=2 (even), send 0x37 with parity bit 0:
  - o_Parity_Err=1, byte 0x37.
  - Resend with parity bit 1: flag 0.
- 8N1, 1-cycle high spike at count mid on data bit 3 of 0x00: byte 0x00, no errors (majority rejects the spike).
- Line held low for 20 bit times, then high, then 0x55:
  - Exactly one strobe with o_Break=1, o_Frame_Err=1.
  - Then 0x55 is received cleanly.
- i_Reset for 1 cycle during data bit 4:
  - No strobe; all outputs 0 the next cycle.
  - No start is accepted until the line has been sampled high.
